// File: rtl/cfg_frame_pkg.sv
// Shared frame geometry, FSM state type and frame packing for the config serializer.
package cfg_frame_pkg;

   localparam int FRAME_BITS = 28;
   localparam int WORD_W     = 5;
   localparam int NWORDS     = 5;
   localparam int BIT_CNT_W  = 5;
   localparam int DIV_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } ser_state_e;

   // Bit 0 goes out first: marker, then word5..word1 LSB first, then the two select bits.
   function automatic logic [FRAME_BITS-1:0] pack_frame(
      input logic [WORD_W-1:0] w1,
      input logic [WORD_W-1:0] w2,
      input logic [WORD_W-1:0] w3,
      input logic [WORD_W-1:0] w4,
      input logic [WORD_W-1:0] w5,
      input logic              clk_sel,
      input logic              out_sel
   );
      return {out_sel, clk_sel, w1, w2, w3, w4, w5, 1'b1};
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: registered tick in the last cycle of every DIV-cycle period while run is high.
module bit_tick_gen
   import cfg_frame_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clock,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(DIV - 1);

   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic                 active_q;
   logic                 tick_q;

   // run describes the coming cycle, so the first period starts fresh at position 0.
   always_comb begin
      cnt_d = '0;
      if (active_q && !tick_q) cnt_d = cnt_q + DIV_CNT_W'(1);
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         active_q <= run;
         cnt_q    <= run ? cnt_d : '0;
         tick_q   <= run && (cnt_d == LAST);
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/cfg_serializer.sv
// Serializes five 5-bit words plus two select bits into a 28-bit marker-led frame with a shift enable.
module cfg_serializer #(
   parameter int DIV        = 1,
   parameter int FRAME_BITS = 28
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] word1,
   input  logic [4:0] word2,
   input  logic [4:0] word3,
   input  logic [4:0] word4,
   input  logic [4:0] word5,
   input  logic       clk_sel_in,
   input  logic       out_sel_in,
   output logic       sdata,
   output logic       sen,
   output logic       busy,
   output logic       done
);
   import cfg_frame_pkg::*;

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

   ser_state_e            state_q;
   logic [BIT_CNT_W-1:0]  bit_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [FRAME_BITS-1:0] frame_in;
   logic                  sdata_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  tick;
   logic                  run;

   assign frame_in = pack_frame(word1, word2, word3, word4, word5, clk_sel_in, out_sel_in);

   // High when the next cycle is a shift cycle; drops with the final tick.
   assign run = (state_q == LOAD) ||
                ((state_q == SHIFT) && !(tick && (bit_q == LAST_BIT)));

   bit_tick_gen #(.DIV(DIV)) u_tick (
      .clock (clock),
      .rst   (rst),
      .run   (run),
      .tick  (tick)
   );

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         frame_q <= '0;
         sdata_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LOAD: begin
               frame_q <= frame_in;
               sdata_q <= frame_in[0];
               bit_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (tick) begin
                  if (bit_q == LAST_BIT) begin
                     sdata_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     bit_q   <= bit_q + BIT_CNT_W'(1);
                     frame_q <= frame_q >> 1;
                     sdata_q <= frame_q[1];
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sdata = sdata_q;
   assign sen   = tick;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_cfg_serializer.sv
// Self-checking bench for cfg_serializer: DIV=1 and DIV=4 instances against a bit-order reference model.
module tb_cfg_serializer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       rst, start1, start4, csel, osel;
   logic [4:0] w1, w2, w3, w4, w5;
   logic       sdata1, sen1, busy1, done1;
   logic       sdata4, sen4, busy4, done4;

   cfg_serializer #(.DIV(1)) dut1 (
      .clock(clock), .rst(rst), .start(start1),
      .word1(w1), .word2(w2), .word3(w3), .word4(w4), .word5(w5),
      .clk_sel_in(csel), .out_sel_in(osel),
      .sdata(sdata1), .sen(sen1), .busy(busy1), .done(done1)
   );

   cfg_serializer #(.DIV(4)) dut4 (
      .clock(clock), .rst(rst), .start(start4),
      .word1(w1), .word2(w2), .word3(w3), .word4(w4), .word5(w5),
      .clk_sel_in(csel), .out_sel_in(osel),
      .sdata(sdata4), .sen(sen4), .busy(busy4), .done(done4)
   );

   // Receiver model: shifts in at the top, marker reaching bit 0 means finished and freezes it.
   logic [27:0] rx;
   logic        rx_clr;
   always @(posedge clock) begin
      if (rx_clr)              rx <= '0;
      else if (sen1 && !rx[0]) rx <= {sdata1, rx[27:1]};
   end

   int n_cmp = 0;
   int n_err = 0;

   logic tr_sen [0:511];
   logic tr_sd  [0:511];
   logic tr_done[0:511];
   logic tr_busy[0:511];

   logic [27:0] exp_vec, got_vec, exp_a;
   int n_pulse, first_sen, last_sen, min_gap, max_gap, n_done, done_at;

   task automatic randomize_inputs();
      w1 = 5'($urandom_range(0, 31));
      w2 = 5'($urandom_range(0, 31));
      w3 = 5'($urandom_range(0, 31));
      w4 = 5'($urandom_range(0, 31));
      w5 = 5'($urandom_range(0, 31));
      csel = 1'($urandom_range(0, 1));
      osel = 1'($urandom_range(0, 1));
   endtask

   // Expected send order, bit k of exp_vec is the k-th bit on the wire.
   task automatic model_frame();
      logic [4:0] w [1:5];
      int k;
      w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
      exp_vec[0] = 1'b1;
      k = 1;
      for (int n = 5; n >= 1; n--)
         for (int b = 0; b < 5; b++) begin
            exp_vec[k] = w[n][b];
            k++;
         end
      exp_vec[26] = csel;
      exp_vec[27] = osel;
   endtask

   // Called at a negedge; cycle 0 drives start, cycle 1 is the LOAD cycle.
   task automatic record(input int sel, input int ncyc, input bit hold, input bit scramble);
      if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clock);
         tr_sen[c]  = (sel == 4) ? sen4  : sen1;
         tr_sd[c]   = (sel == 4) ? sdata4 : sdata1;
         tr_done[c] = (sel == 4) ? done4 : done1;
         tr_busy[c] = (sel == 4) ? busy4 : busy1;
         if (c == 1 && !hold) begin start1 = 1'b0; start4 = 1'b0; end
         if (c == 3 && scramble) randomize_inputs();
      end
   endtask

   task automatic extract(input int lo, input int hi);
      n_pulse = 0; first_sen = -1; last_sen = -1;
      min_gap = 1000; max_gap = 0; n_done = 0; done_at = -1;
      got_vec = 'x;
      for (int c = lo; c <= hi; c++) begin
         if (tr_sen[c] === 1'b1) begin
            if (n_pulse < 28) got_vec[n_pulse] = tr_sd[c];
            if (last_sen >= 0) begin
               if (c - last_sen < min_gap) min_gap = c - last_sen;
               if (c - last_sen > max_gap) max_gap = c - last_sen;
            end
            if (first_sen < 0) first_sen = c;
            last_sen = c;
            n_pulse++;
         end
         if (tr_done[c] === 1'b1) begin n_done++; done_at = c; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start1 = 1'b1; start4 = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({sdata1, sen1, busy1, done1} !== 4'b0000) begin
         n_err++; $display("FAIL reset_dut1: got %b want 0000", {sdata1, sen1, busy1, done1});
      end
      n_cmp++;
      if ({sdata4, sen4, busy4, done4} !== 4'b0000) begin
         n_err++; $display("FAIL reset_dut4: got %b want 0000", {sdata4, sen4, busy4, done4});
      end
      start1 = 1'b0; start4 = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({busy1, busy4, sen1, sen4} !== 4'b0000) begin
         n_err++; $display("FAIL reset_release_idle: got %b want 0000", {busy1, busy4, sen1, sen4});
      end
   endtask

   task automatic test_frame_pattern();
      logic [27:0] seq_msb, got_msb;
      logic        all_sen;
      seq_msb = 28'b1_00001_00010_00100_01000_10000_1_0;
      w1 = 5'h01; w2 = 5'h02; w3 = 5'h04; w4 = 5'h08; w5 = 5'h10; csel = 1'b1; osel = 1'b0;
      record(1, 35, 1'b0, 1'b0);
      extract(1, 35);
      for (int i = 0; i < 28; i++) got_msb[27-i] = got_vec[i];
      n_cmp++;
      if (got_msb !== seq_msb) begin
         n_err++; $display("FAIL pattern_bits: got %b want %b", got_msb, seq_msb);
      end
      all_sen = 1'b1;
      for (int c = 2; c <= 29; c++) all_sen &= tr_sen[c];
      n_cmp++;
      if (!(all_sen === 1'b1 && n_pulse == 28 && first_sen == 2 && last_sen == 29)) begin
         n_err++; $display("FAIL pattern_sen: got %0d pulses %0d..%0d want 28 pulses 2..29", n_pulse, first_sen, last_sen);
      end
      n_cmp++;
      if (n_done != 1 || done_at != 30) begin
         n_err++; $display("FAIL pattern_done: got %0d pulses at %0d want 1 at 30", n_done, done_at);
      end
      n_cmp++;
      if ({tr_busy[1], tr_sen[1], tr_sd[1], tr_busy[30], tr_sen[30], tr_sd[30], tr_busy[31]} !== 7'b100_100_0) begin
         n_err++; $display("FAIL pattern_edges: got %b want 1001000",
                           {tr_busy[1], tr_sen[1], tr_sd[1], tr_busy[30], tr_sen[30], tr_sd[30], tr_busy[31]});
      end
   endtask

   task automatic test_loopback();
      rx_clr = 1'b1;
      @(negedge clock);
      rx_clr = 1'b0;
      w1 = 5'h15; w2 = 5'h0A; w3 = 5'h1F; w4 = 5'h00; w5 = 5'h11; csel = 1'b1; osel = 1'b1;
      record(1, 45, 1'b0, 1'b0);
      extract(1, 45);
      n_cmp++;
      if (rx[0] !== 1'b1) begin
         n_err++; $display("FAIL loop_finished: got %b want 1", rx[0]);
      end
      n_cmp++;
      if ({rx[25:21], rx[20:16], rx[15:11], rx[10:6], rx[5:1]} !== {5'h15, 5'h0A, 5'h1F, 5'h00, 5'h11}) begin
         n_err++; $display("FAIL loop_words: got %h want %h",
                           {rx[25:21], rx[20:16], rx[15:11], rx[10:6], rx[5:1]}, {5'h15, 5'h0A, 5'h1F, 5'h00, 5'h11});
      end
      n_cmp++;
      if (rx[27:26] !== 2'b11) begin
         n_err++; $display("FAIL loop_selects: got %b want 11", rx[27:26]);
      end
      n_cmp++;
      if (n_pulse != 28 || last_sen != 29) begin
         n_err++; $display("FAIL loop_no_extra_shift: got %0d pulses last %0d want 28 last 29", n_pulse, last_sen);
      end
   endtask

   task automatic test_random_frames();
      int d, ncyc;
      for (int i = 0; i < 6; i++) begin
         d = (i % 2 == 1) ? 4 : 1;
         ncyc = 28 * d + 6;
         randomize_inputs();
         model_frame();
         record(d, ncyc, 1'b0, 1'b1);
         extract(1, ncyc);
         n_cmp++;
         if (got_vec !== exp_vec) begin
            n_err++; $display("FAIL rand_bits div%0d: got %h want %h", d, got_vec, exp_vec);
         end
         n_cmp++;
         if (n_pulse != 28 || first_sen != 1 + d || min_gap != d || max_gap != d) begin
            n_err++; $display("FAIL rand_timing div%0d: got n=%0d first=%0d gap=%0d..%0d want n=28 first=%0d gap=%0d",
                              d, n_pulse, first_sen, min_gap, max_gap, 1 + d, d);
         end
         n_cmp++;
         if (n_done != 1 || done_at != 2 + 28 * d) begin
            n_err++; $display("FAIL rand_done div%0d: got %0d at %0d want 1 at %0d", d, n_done, done_at, 2 + 28 * d);
         end
      end
   endtask

   task automatic test_pacing();
      int bad_sd, bad_sen;
      logic want_sen;
      randomize_inputs();
      model_frame();
      record(4, 120, 1'b0, 1'b1);
      bad_sd = 0; bad_sen = 0;
      for (int c = 2; c <= 113; c++)
         if (tr_sd[c] !== exp_vec[(c - 2) / 4]) bad_sd++;
      if (tr_sd[1] !== 1'b0) bad_sd++;
      for (int c = 114; c <= 120; c++)
         if (tr_sd[c] !== 1'b0) bad_sd++;
      for (int c = 1; c <= 120; c++) begin
         want_sen = (c >= 5 && c <= 113 && (c - 1) % 4 == 0);
         if (tr_sen[c] !== want_sen) bad_sen++;
      end
      n_cmp++;
      if (bad_sd != 0) begin
         n_err++; $display("FAIL pace_sdata_stable: got %0d bad cycles want 0", bad_sd);
      end
      n_cmp++;
      if (bad_sen != 0) begin
         n_err++; $display("FAIL pace_sen_spacing: got %0d bad cycles want 0", bad_sen);
      end
      n_cmp++;
      if (tr_done[114] !== 1'b1) begin
         n_err++; $display("FAIL pace_done: got %b at 114 want 1", tr_done[114]);
      end
   endtask

   task automatic test_busy_held_start();
      randomize_inputs();
      model_frame();
      exp_a = exp_vec;
      start1 = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clock);
         tr_sen[c] = sen1; tr_sd[c] = sdata1; tr_done[c] = done1; tr_busy[c] = busy1;
         if (c == 1)  start1 = 1'b0;
         if (c == 12) start1 = 1'b1;
         if (c == 13) start1 = 1'b0;
         if (c == 14) begin randomize_inputs(); model_frame(); end
         if (c == 20) start1 = 1'b1;
         if (c == 33) start1 = 1'b0;
      end
      extract(1, 31);
      n_cmp++;
      if (got_vec !== exp_a) begin
         n_err++; $display("FAIL busy_frame_a_bits: got %h want %h", got_vec, exp_a);
      end
      n_cmp++;
      if (n_pulse != 28 || first_sen != 2 || last_sen != 29 || n_done != 1 || done_at != 30) begin
         n_err++; $display("FAIL busy_frame_a_timing: got n=%0d %0d..%0d done@%0d want n=28 2..29 done@30",
                           n_pulse, first_sen, last_sen, done_at);
      end
      n_cmp++;
      if ({tr_busy[31], tr_busy[32], tr_sen[32]} !== 3'b010) begin
         n_err++; $display("FAIL held_start_reload: got %b want 010", {tr_busy[31], tr_busy[32], tr_sen[32]});
      end
      extract(32, 70);
      n_cmp++;
      if (got_vec !== exp_vec) begin
         n_err++; $display("FAIL held_frame_b_bits: got %h want %h", got_vec, exp_vec);
      end
      n_cmp++;
      if (n_pulse != 28 || first_sen != 33 || n_done != 1 || done_at != 61) begin
         n_err++; $display("FAIL held_frame_b_timing: got n=%0d first=%0d done@%0d want n=28 first=33 done@61",
                           n_pulse, first_sen, done_at);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic seen;
      randomize_inputs();
      model_frame();
      start1 = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clock);
         if (c == 1) start1 = 1'b0;
      end
      n_cmp++;
      if (sen1 !== 1'b1) begin
         n_err++; $display("FAIL midrst_pre_sen: got %b want 1", sen1);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({sdata1, sen1, busy1} !== 3'b000) begin
         n_err++; $display("FAIL midrst_immediate: got %b want 000", {sdata1, sen1, busy1});
      end
      seen = 1'b0;
      repeat (3) @(negedge clock) seen |= sen1 | done1 | busy1 | sdata1;
      rst = 1'b1;
      repeat (5) @(negedge clock) seen |= sen1 | done1 | busy1 | sdata1;
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL midrst_quiet: got activity %b want 0", seen);
      end
      randomize_inputs();
      model_frame();
      record(1, 35, 1'b0, 1'b0);
      extract(1, 35);
      n_cmp++;
      if (got_vec !== exp_vec || n_pulse != 28 || done_at != 30) begin
         n_err++; $display("FAIL midrst_restart: got %h n=%0d done@%0d want %h n=28 done@30",
                           got_vec, n_pulse, done_at, exp_vec);
      end
   endtask

   initial begin
      rst = 1'b0; start1 = 1'b0; start4 = 1'b0; rx_clr = 1'b1;
      w1 = '0; w2 = '0; w3 = '0; w4 = '0; w5 = '0; csel = 1'b0; osel = 1'b0;
      test_reset();
      test_frame_pattern();
      test_loopback();
      test_random_frames();
      test_pacing();
      test_busy_held_start();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
